// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states
// and fixed latencies used by both the pipeline controller and the MDU.
package mdu_pkg;

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6,
        OP_RSVD  = 3'd7
    } mdu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mdu_state_e;

    localparam int unsigned MULT_CYCLES = 5;
    localparam int unsigned DIV_CYCLES  = 10;

    // Counter reload values: the final busy cycle is the one where the counter reads zero.
    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

    function automatic logic [63:0] mul64(input logic [31:0] x, input logic [31:0] y,
                                          input logic sgn);
        logic [63:0] xe;
        logic [63:0] ye;
        xe = {{32{sgn & x[31]}}, x};
        ye = {{32{sgn & y[31]}}, y};
        return xe * ye;
    endfunction

endpackage

// File: rtl/mdu.sv
// HI/LO multiply/divide unit: results are computed at launch, parked in shadow
// registers, and committed to HI/LO only when the fixed busy window expires.
module mdu
    import mdu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    mdu_state_e  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] sh_hi_q, sh_hi_d;
    logic [31:0] sh_lo_q, sh_lo_d;
    logic        sh_wr_q, sh_wr_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    mdu_op_e     op_e;
    logic        is_mul, is_div, launch, commit;
    logic [63:0] prod;
    logic        a_neg, b_neg;
    logic [31:0] ua, ub, ub_safe, uq, ur, quo, rem;

    assign op_e   = mdu_op_e'(op);
    assign is_mul = (op_e == OP_MULT) || (op_e == OP_MULTU);
    assign is_div = (op_e == OP_DIV) || (op_e == OP_DIVU);
    assign launch = start && (state_q == ST_IDLE) && (op_e != OP_NONE) && (op_e != OP_RSVD);
    assign commit = (state_q == ST_BUSY) && (cnt_q == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sh_hi_q <= '0;
            sh_lo_q <= '0;
            sh_wr_q <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_hi_q <= sh_hi_d;
            sh_lo_q <= sh_lo_d;
            sh_wr_q <= sh_wr_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (launch && (is_mul || is_div)) begin
                    state_d = ST_BUSY;
                    cnt_d   = is_mul ? MULT_LOAD : DIV_LOAD;
                end
            end
            ST_BUSY: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Signed division runs on magnitudes; the most-negative dividend over -1
    // wraps back to 0x80000000 naturally with no special case.
    always_comb begin
        prod    = mul64(a, b, op_e == OP_MULT);
        a_neg   = (op_e == OP_DIV) && a[31];
        b_neg   = (op_e == OP_DIV) && b[31];
        ua      = a_neg ? -a : a;
        ub      = b_neg ? -b : b;
        ub_safe = (ub == '0) ? 32'd1 : ub;
        uq      = ua / ub_safe;
        ur      = ua % ub_safe;
        quo     = (a_neg ^ b_neg) ? -uq : uq;
        rem     = a_neg ? -ur : ur;

        sh_hi_d = sh_hi_q;
        sh_lo_d = sh_lo_q;
        sh_wr_d = sh_wr_q;
        if (launch && is_mul) begin
            sh_hi_d = prod[63:32];
            sh_lo_d = prod[31:0];
            sh_wr_d = 1'b1;
        end else if (launch && is_div) begin
            sh_hi_d = rem;
            sh_lo_d = quo;
            sh_wr_d = (b != '0);
        end

        hi_d = hi_q;
        lo_d = lo_q;
        if (commit && sh_wr_q) begin
            hi_d = sh_hi_q;
            lo_d = sh_lo_q;
        end
        if (launch && (op_e == OP_MTHI)) hi_d = a;
        if (launch && (op_e == OP_MTLO)) lo_d = a;
    end

    always_comb begin
        busy = (state_q == ST_BUSY);
        hi   = hi_q;
        lo   = lo_q;
    end

endmodule

// File: tb/tb_mdu.sv
// Randomized scoreboard bench for mdu: the stimulus side predicts HI/LO and the
// commit cycle with 64-bit arithmetic; a negedge monitor checks every cycle.
module tb_mdu;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        busy;
    logic [31:0] hi, lo;

    mdu dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          issue;
        int          due;
        bit          long_op;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    bit          mon_en = 0;
    logic [31:0] ref_hi = '0;
    logic [31:0] ref_lo = '0;

    logic [31:0] s_hi = '0;
    logic [31:0] s_lo = '0;
    int          s_due = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            logic exp_busy;
            if (sb.size() > 0 && sb[0].due == cyc) begin
                ref_hi = sb[0].hi;
                ref_lo = sb[0].lo;
                void'(sb.pop_front());
            end
            exp_busy = (sb.size() > 0) && sb[0].long_op && (cyc > sb[0].issue) && (cyc < sb[0].due);
            chk("busy", {31'b0, busy}, {31'b0, exp_busy});
            chk("hi", hi, ref_hi);
            chk("lo", lo, ref_lo);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint          sx, sy, p, q, r;
        longint unsigned ux, uy, up;
        logic [63:0]     w;
        logic [31:0]     nh, nl;
        int              lat;
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        if (o >= 3'd1 && o <= 3'd6 && cyc >= s_due) begin
            sx = $signed(x);
            sy = $signed(y);
            ux = {32'b0, x};
            uy = {32'b0, y};
            nh = s_hi;
            nl = s_lo;
            lat = 10;
            case (o)
                3'd1: begin p = sx * sy; w = p; nh = w[63:32]; nl = w[31:0]; lat = 5; end
                3'd2: begin up = ux * uy; nh = up[63:32]; nl = up[31:0]; lat = 5; end
                3'd3: if (y != 0) begin
                    q = sx / sy; r = sx % sy;
                    w = q; nl = w[31:0];
                    w = r; nh = w[31:0];
                end
                3'd4: if (y != 0) begin
                    up = ux / uy; nl = up[31:0];
                    up = ux % uy; nh = up[31:0];
                end
                3'd5: nh = x;
                default: nl = x;
            endcase
            s_hi = nh;
            s_lo = nl;
            if (o <= 3'd4) begin
                s_due = cyc + lat + 1;
                sb.push_back('{cyc, s_due, 1'b1, nh, nl});
            end else begin
                sb.push_back('{cyc, cyc + 1, 1'b0, nh, nl});
            end
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20 && cyc < s_due; i++) step();
    endtask

    task automatic do_reset();
        start = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        sb.delete();
        sb.push_back('{cyc, cyc, 1'b0, 32'h0, 32'h0});
        s_hi  = '0;
        s_lo  = '0;
        s_due = 0;
    endtask

    initial begin
        logic [2:0]  ro;
        logic [31:0] ra, rb;
        reset = 1'b1;
        start = 1'b0;
        op    = '0;
        a     = '0;
        b     = '0;
        repeat (3) @(posedge clk);
        #1;
        reset  = 1'b0;
        mon_en = 1'b1;
        step();

        issue(3'd1, 32'hFFFFFFFE, 32'd3);          step(); wait_idle();
        issue(3'd2, 32'hFFFFFFFF, 32'd2);          step(); wait_idle();
        issue(3'd3, 32'hFFFFFFF9, 32'd2);          step(); wait_idle();
        issue(3'd4, 32'h00001234, 32'd0);          step(); wait_idle();
        issue(3'd3, 32'h80000000, 32'hFFFFFFFF);   step(); wait_idle();
        issue(3'd3, 32'h00000007, 32'hFFFFFFFE);   step(); wait_idle();
        issue(3'd5, 32'h12345678, 32'd0);          step();
        issue(3'd6, 32'h9ABCDEF0, 32'd0);          step();
        issue(3'd0, 32'hDEADBEEF, 32'd1);          step();
        issue(3'd7, 32'hDEADBEEF, 32'd1);          step();
        step();

        // MTLO during busy is ignored; reset mid-flight drops the product.
        issue(3'd1, 32'h00010000, 32'h00010000);   step();
        step();
        issue(3'd6, 32'h55555555, 32'd0);          step();
        do_reset();
        repeat (8) step();

        // Back-to-back divides, second launched the cycle busy falls.
        issue(3'd4, 32'd100, 32'd7);               step(); wait_idle();
        issue(3'd3, 32'hFFFFFF9C, 32'd7);          step(); wait_idle();
        step();

        for (int i = 0; i < 400; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = $urandom();
            rb = $urandom();
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: rb = 32'hFFFFFFFF;
                2: ra = 32'h80000000;
                default: ;
            endcase
            if ($urandom_range(0, 2) != 0) issue(ro, ra, rb);
            step();
        end

        for (int i = 0; i < 30 && sb.size() > 0; i++) step();
        step();
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain cyc=%0d got=%0d pending exp=0", cyc, sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
